// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between data and instruction caches
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_strobe,
    input  logic              r0_rw,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_data_in,
    output logic [DATA_W-1:0] r0_data_out,
    output logic              r0_ready,
    input  logic              r1_strobe,
    input  logic              r1_rw,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_data_in,
    output logic [DATA_W-1:0] r1_data_out,
    output logic              r1_ready,
    output logic              S_strobe,
    output logic              S_rw,
    output logic [ADDR_W-1:0] S_address,
    output logic [DATA_W-1:0] S_data_out,
    input  logic [DATA_W-1:0] S_data_in,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              winner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        // On a tie the port that did not win last time goes first
        winner       = (r0_strobe && r1_strobe) ? ~last_grant_q : r1_strobe;
        case (state_q)
            IDLE: begin
                if (r0_strobe || r1_strobe) begin
                    grant_d = winner;
                    addr_d  = winner ? r1_address : r0_address;
                    rw_d    = winner ? r1_rw      : r0_rw;
                    wdata_d = winner ? r1_data_in : r0_data_in;
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!rw_q) begin
                        if (grant_q) rdata1_d = S_data_in;
                        else         rdata0_d = S_data_in;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign S_strobe    = (state_q == ACCESS);
    assign S_address   = S_strobe ? addr_q : '0;
    assign S_rw        = S_strobe & rw_q;
    assign S_data_out  = (S_strobe && rw_q) ? wdata_q : '0;
    assign r0_ready    = (state_q == RESP) && !grant_q;
    assign r1_ready    = (state_q == RESP) && grant_q;
    assign r0_data_out = rdata0_q;
    assign r1_data_out = rdata1_q;
    assign busy        = (state_q != IDLE);
    assign grant       = grant_q;

endmodule
